nd_tx_serializer: RTL and testbench

Drains the non-data packet FIFO (handshake and token packets, stored as 8-bit chunks) and serializes each packet onto the USB transmit bit path. Each packet is emitted as SYNC, then its bytes LSB-first, with USB bit stuffing, then EOP. It is the read-side counterpart of the non-data FIFO's writer and feeds the line encoder, which performs NRZI and drives D+/D-.

---
 rtl/nd_tx_serializer_if.sv | 21 ++
 rtl/nd_tx_serializer.sv | 150 +++++++++++++++
 tb/tb_nd_tx_serializer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nd_tx_serializer_if.sv
// Read side of the non-data packet FIFO (first-word-fall-through head byte).
// The serializer uses the master modport; the FIFO uses the slave modport.
interface nd_tx_serializer_if;
  localparam int unsigned DataW = 8;

  logic             fifo_empty;
  logic [DataW-1:0] fifo_r_data;
  logic             fifo_r_enable;

  modport master (
    input  fifo_empty,
    input  fifo_r_data,
    output fifo_r_enable
  );

  modport slave (
    output fifo_empty,
    output fifo_r_data,
    input  fifo_r_enable
  );
endinterface

// File: rtl/nd_tx_serializer.sv
// Drains length-framed handshake/token packets from the non-data FIFO and
// serializes SYNC + payload LSB-first with USB bit stuffing, followed by EOP.
module nd_tx_serializer #(
  parameter int unsigned MAX_LEN   = 3,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic               clk,
  input  logic               rst,
  nd_tx_serializer_if.master fifo,
  input  logic               shift_strobe,
  output logic               tx_bit,
  output logic               tx_active,
  output logic               tx_eop,
  output logic               tx_err
);
  localparam int unsigned ByteW = 8;
  localparam int unsigned LenW  = $clog2(MAX_LEN + 1);
  localparam int unsigned BitW  = 3;
  localparam int unsigned OnesW = 3;
  localparam logic [OnesW-1:0] StuffAt  = OnesW'(6);
  localparam logic [BitW-1:0]  LastBit  = BitW'(7);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP1,
    S_EOP2
  } state_e;

  state_e           state_q;
  logic [ByteW-1:0] shreg_q;
  logic [LenW-1:0]  bytes_left_q;
  logic [BitW-1:0]  bitcnt_q;
  logic [OnesW-1:0] ones_q;
  logic             stuff_q;
  logic             done_q;
  logic             tx_bit_q;
  logic             tx_active_q;
  logic             tx_eop_q;
  logic             tx_err_q;

  logic             len_ok;
  logic             shifting;
  logic             boundary;
  logic             pop_len;
  logic             pop_data;
  logic [OnesW-1:0] ones_d;

  assign len_ok   = (fifo.fifo_r_data != '0) && (fifo.fifo_r_data <= ByteW'(MAX_LEN));
  assign shifting = shift_strobe && (state_q == S_SYNC || state_q == S_DATA) && !stuff_q && !done_q;
  assign boundary = shifting && (bitcnt_q == LastBit);
  assign ones_d   = shreg_q[0] ? ones_q + OnesW'(1) : '0;

  // Pops are combinational so the FWFT head is consumed on the same edge it is used.
  assign pop_len            = !rst && (state_q == S_IDLE) && !fifo.fifo_empty;
  assign pop_data           = !rst && boundary && (bytes_left_q != '0) && !fifo.fifo_empty;
  assign fifo.fifo_r_enable = pop_len || pop_data;

  // done_q marks that the last wire bit (or a trailing stuffed 0) is on the line;
  // the following strobe starts the first EOP bit time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      bytes_left_q <= '0;
      bitcnt_q     <= '0;
      ones_q       <= '0;
      stuff_q      <= 1'b0;
      done_q       <= 1'b0;
      tx_bit_q     <= 1'b1;
      tx_active_q  <= 1'b0;
      tx_eop_q     <= 1'b0;
      tx_err_q     <= 1'b0;
    end else begin
      tx_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (!fifo.fifo_empty) begin
            if (len_ok) begin
              bytes_left_q <= LenW'(fifo.fifo_r_data);
              shreg_q      <= SYNC_BYTE;
              bitcnt_q     <= '0;
              ones_q       <= '0;
              stuff_q      <= 1'b0;
              done_q       <= 1'b0;
              state_q      <= S_SYNC;
            end else begin
              tx_err_q <= 1'b1;
            end
          end
        end
        S_SYNC, S_DATA: begin
          if (shift_strobe) begin
            tx_active_q <= 1'b1;
            if (stuff_q) begin
              tx_bit_q <= 1'b0;
              ones_q   <= '0;
              stuff_q  <= 1'b0;
            end else if (done_q) begin
              tx_bit_q <= 1'b1;
              tx_eop_q <= 1'b1;
              done_q   <= 1'b0;
              state_q  <= S_EOP1;
            end else begin
              tx_bit_q <= shreg_q[0];
              shreg_q  <= shreg_q >> 1;
              bitcnt_q <= bitcnt_q + BitW'(1);
              ones_q   <= ones_d;
              stuff_q  <= (ones_d == StuffAt);
              if (boundary) begin
                if (bytes_left_q == '0) begin
                  done_q <= 1'b1;
                end else if (!fifo.fifo_empty) begin
                  shreg_q      <= fifo.fifo_r_data;
                  bytes_left_q <= bytes_left_q - LenW'(1);
                  state_q      <= S_DATA;
                end else begin
                  // Underrun: truncate the packet and go straight to EOP.
                  tx_err_q <= 1'b1;
                  stuff_q  <= 1'b0;
                  done_q   <= 1'b1;
                end
              end
            end
          end
        end
        S_EOP1: begin
          if (shift_strobe) begin
            state_q <= S_EOP2;
          end
        end
        S_EOP2: begin
          if (shift_strobe) begin
            tx_bit_q    <= 1'b1;
            tx_eop_q    <= 1'b0;
            tx_active_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_bit    = tx_bit_q;
  assign tx_active = tx_active_q;
  assign tx_eop    = tx_eop_q;
  assign tx_err    = tx_err_q;
endmodule

// File: tb/tb_nd_tx_serializer.sv
// Scoreboard bench for nd_tx_serializer: a FWFT FIFO model, a packet-level wire
// model that fills an expected-symbol queue, and a monitor that checks every strobe.
module tb_nd_tx_serializer;
  localparam int unsigned MaxLen = 3;
  localparam int          EopSym = 2;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  logic shift_strobe;
  logic tx_bit;
  logic tx_active;
  logic tx_eop;
  logic tx_err;

  nd_tx_serializer_if fifo_if ();

  nd_tx_serializer #(
    .MAX_LEN  (MaxLen),
    .SYNC_BYTE(8'h80)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo        (fifo_if),
    .shift_strobe(shift_strobe),
    .tx_bit      (tx_bit),
    .tx_active   (tx_active),
    .tx_eop      (tx_eop),
    .tx_err      (tx_err)
  );

  always #5 clk = ~clk;

  // FIFO model: writer pushes at negedge, pops land on the clock edge.
  logic [7:0]  mem [0:4095];
  logic [11:0] wr_ptr = '0;
  logic [11:0] rd_ptr = '0;
  int          pop_cnt = 0;

  assign fifo_if.fifo_empty  = (wr_ptr == rd_ptr);
  assign fifo_if.fifo_r_data = mem[rd_ptr];

  always @(posedge clk) begin
    if (fifo_if.fifo_r_enable) begin
      rd_ptr  <= rd_ptr + 12'd1;
      pop_cnt <= pop_cnt + 1;
    end
  end

  // Bit-time strobe: one pulse every strobe_div cycles.
  int strobe_div = 1;
  initial begin
    int scnt;
    scnt = 0;
    shift_strobe = 1'b0;
    forever begin
      @(negedge clk);
      scnt = (scnt + 1 >= strobe_div) ? 0 : scnt + 1;
      shift_strobe = (scnt == 0);
    end
  end

  int exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_pops = 0;
  int exp_errs = 0;
  int err_cnt = 0;
  int act_strobes = 0;
  bit mon_en = 1'b1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one wire symbol per active strobe (0/1 bit, 2 = EOP bit time).
  initial begin
    logic s, r, pb, pe;
    int   sym;
    pb = 1'b1;
    pe = 1'b0;
    forever begin
      @(posedge clk);
      s = shift_strobe;
      r = rst;
      #1;
      if (tx_err) err_cnt++;
      if (!r && s && tx_active) act_strobes++;
      if (!r && mon_en) begin
        if (s && tx_active) begin
          sym = tx_eop ? EopSym : int'(tx_bit);
          if (exp_q.size() == 0) begin
            chk("wire_sym_unexpected", sym, -1);
          end else begin
            chk("wire_sym", sym, exp_q.pop_front());
          end
        end else if (!s) begin
          chk("hold_tx_bit", int'(tx_bit), int'(pb));
          chk("hold_tx_eop", int'(tx_eop), int'(pe));
        end
        if (!tx_active) begin
          chk("idle_tx_bit", int'(tx_bit), 1);
          chk("idle_tx_eop", int'(tx_eop), 0);
        end
      end
      pb = tx_bit;
      pe = tx_eop;
    end
  end

  // Wire model of one FIFO item: length byte plus whatever payload bytes exist.
  task automatic expect_item(input bq_t pkt);
    int         len;
    int         avail;
    int         ones;
    bit         stuffed_last;
    int         bits[$];
    logic [7:0] sync_b;
    logic [7:0] cur;
    sync_b = 8'h80;
    len    = int'(pkt[0]);
    exp_pops++;
    if (len == 0 || len > int'(MaxLen)) begin
      exp_errs++;
      return;
    end
    avail = pkt.size() - 1;
    if (avail > len) avail = len;
    exp_pops += avail;
    for (int i = 0; i < 8; i++) bits.push_back(int'(sync_b[i]));
    for (int k = 1; k <= avail; k++) begin
      cur = pkt[k];
      for (int i = 0; i < 8; i++) bits.push_back(int'(cur[i]));
    end
    ones = 0;
    stuffed_last = 1'b0;
    foreach (bits[i]) begin
      exp_q.push_back(bits[i]);
      stuffed_last = 1'b0;
      ones = (bits[i] == 1) ? ones + 1 : 0;
      if (ones == 6) begin
        exp_q.push_back(0);
        ones = 0;
        stuffed_last = 1'b1;
      end
    end
    if (avail < len) begin
      exp_errs++;
      if (stuffed_last) void'(exp_q.pop_back());
    end
    exp_q.push_back(EopSym);
    exp_q.push_back(EopSym);
  endtask

  task automatic push_bytes(input bq_t b);
    @(negedge clk);
    foreach (b[i]) begin
      mem[wr_ptr] = b[i];
      wr_ptr = wr_ptr + 12'd1;
    end
  endtask

  task automatic send_pkt(input bq_t item);
    expect_item(item);
    push_bytes(item);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (n < budget && !(exp_q.size() == 0 && fifo_if.fifo_empty && !tx_active)) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      chk({name, "_timeout_left"}, exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #2;
    chk({name, "_pops"}, pop_cnt, exp_pops);
    chk({name, "_errs"}, err_cnt, exp_errs);
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 3))
      0:       return 8'hFF;
      1:       return 8'h7F;
      2:       return 8'hFC;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t item;
    int  p0;
    int  n;
    int  base;
    int  len;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_bit", int'(tx_bit), 1);
    chk("reset_tx_active", int'(tx_active), 0);
    chk("reset_tx_eop", int'(tx_eop), 0);
    chk("reset_tx_err", int'(tx_err), 0);

    // ACK queued while reset is still asserted: no pop may happen yet.
    item = '{8'h01, 8'hD2};
    expect_item(item);
    push_bytes(item);
    @(posedge clk);
    #1;
    chk("reset_no_enable", int'(fifo_if.fifo_r_enable), 0);
    chk("reset_no_pop", pop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_idle(2000, "ack");

    item = '{8'h01, 8'hFF};
    send_pkt(item);
    wait_idle(2000, "stuff");

    item = '{8'h02, 8'h00, 8'hFC};
    send_pkt(item);
    wait_idle(2000, "trail_stuff");

    item = '{8'h05};
    send_pkt(item);
    item = '{8'h01, 8'h5A};
    send_pkt(item);
    wait_idle(2000, "bad_len");

    item = '{8'h03, 8'hE1};
    send_pkt(item);
    wait_idle(2000, "underrun");
    chk("underrun_fifo_empty", int'(fifo_if.fifo_empty), 1);

    item = '{8'h02, 8'hFF, 8'hFF};
    send_pkt(item);
    item = '{8'h03, 8'h7E, 8'hFF, 8'h3F};
    send_pkt(item);
    wait_idle(4000, "back_to_back");

    // Reset in the middle of PID bit 3, coincident with a strobe.
    strobe_div = 4;
    mon_en = 1'b0;
    exp_pops += 2;
    item = '{8'h01, 8'hD2};
    base = act_strobes;
    push_bytes(item);
    n = 0;
    while (act_strobes < base + 12 && n < 2000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("abort_reached_pid_bit3", int'(act_strobes >= base + 12), 1);
    push_bytes(item);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!shift_strobe && n < 100);
    rst = 1'b1;
    p0 = pop_cnt;
    @(posedge clk);
    #1;
    chk("midreset_tx_active", int'(tx_active), 0);
    chk("midreset_tx_bit", int'(tx_bit), 1);
    chk("midreset_tx_eop", int'(tx_eop), 0);
    chk("midreset_no_enable", int'(fifo_if.fifo_r_enable), 0);
    chk("midreset_no_pop", pop_cnt, p0);
    @(negedge clk);
    expect_item(item);
    mon_en = 1'b1;
    rst = 1'b0;
    wait_idle(4000, "ack_after_reset");

    // Randomised traffic with varying bit-time divisors and gaps.
    for (int b = 0; b < 4; b++) begin
      strobe_div = int'($urandom_range(1, 4));
      for (int p = 0; p < 12; p++) begin
        item.delete();
        if ($urandom_range(0, 7) == 0) begin
          item.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(4, 255)));
        end else begin
          len = int'($urandom_range(1, MaxLen));
          item.push_back(8'(len));
          for (int k = 0; k < len; k++) item.push_back(pick_byte());
        end
        send_pkt(item);
        repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_idle(20000, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
